// File: rtl/div_seq_pkg.sv
// Shared constants, state encoding and small helpers for the sequential
// DIV/IDIV unit.
package div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam int DIV_ITERS_W = 16;
  localparam int DIV_ITERS_B = 8;

  // Bit offsets of the fields inside the 32-bit ALU mul/div result word.
  localparam int OUT_QUO_LSB   = 0;
  localparam int OUT_REM_W_LSB = 16;
  localparam int OUT_REM_B_LSB = 8;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [15:0] cond_neg16(input logic [15:0] v, input logic neg);
    return neg ? (~v + 16'd1) : v;
  endfunction

  function automatic logic [7:0] cond_neg8(input logic [7:0] v, input logic neg);
    return neg ? (~v + 8'd1) : v;
  endfunction

  function automatic logic [31:0] pack_result(input logic word, input logic [15:0] quo,
                                              input logic [15:0] rem);
    logic [31:0] res;
    res = '0;
    if (word) begin
      res[OUT_REM_W_LSB +: 16] = rem;
      res[OUT_QUO_LSB +: 16]   = quo;
    end else begin
      res[OUT_REM_B_LSB +: 8] = rem[7:0];
      res[OUT_QUO_LSB +: 8]   = quo[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor and shift the resulting quotient bit into quo[0].
module div_step (
  input  logic [15:0] rem_i,
  input  logic [15:0] quo_i,
  input  logic [15:0] dvsr_i,
  output logic [15:0] rem_o,
  output logic [15:0] quo_o
);

  logic [16:0] shifted;
  logic [17:0] trial;
  logic        borrow;
  logic        unused_hi;

  always_comb begin
    shifted = {rem_i, quo_i[15]};
    trial   = {1'b0, shifted} - {2'b00, dvsr_i};
    borrow  = trial[17];
    // rem < divisor on entry, so the kept value always fits in 16 bits.
    rem_o   = borrow ? shifted[15:0] : trial[15:0];
    quo_o   = {quo_i[14:0], ~borrow};
  end

  assign unused_hi = shifted[16] ^ trial[16];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/IDIV unit: magnitude restoring division, one quotient bit per
// clock, with 8086 divide-error detection and ALU-compatible result packing.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [15:0] y,
  input  logic        signed_op,
  input  logic        word_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        div_exc
);

  div_state_t  state_q, state_d;
  logic [15:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        word_q, word_d, sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [31:0] out_q, out_d;
  logic        exc_q, exc_d;
  // Operands of a start accepted in the DONE cycle, launched from IDLE next.
  logic        pend_q, pend_d;
  logic [31:0] px_q, px_d;
  logic [15:0] py_q, py_d;
  logic        psgn_q, psgn_d, pword_q, pword_d;

  logic [31:0] l_x;
  logic [15:0] l_y;
  logic        l_sgn, l_word, launch;
  logic        dd_neg, dv_neg, over;
  logic [31:0] dd_mag;
  logic [15:0] dv_mag, rem_init, quo_init;
  logic [15:0] step_rem, step_quo;
  logic [15:0] qm, rm, qs, rs;
  logic        range_exc;
  logic [31:0] fix_out;

  div_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    l_x    = pend_q ? px_q    : x;
    l_y    = pend_q ? py_q    : y;
    l_sgn  = pend_q ? psgn_q  : signed_op;
    l_word = pend_q ? pword_q : word_op;
    launch = pend_q | start;
    dd_neg = l_sgn & (l_word ? l_x[31] : l_x[15]);
    dv_neg = l_sgn & (l_word ? l_y[15] : l_y[7]);
    if (l_word) begin
      dd_mag   = cond_neg32(l_x, dd_neg);
      dv_mag   = cond_neg16(l_y, dv_neg);
      rem_init = dd_mag[31:16];
      quo_init = dd_mag[15:0];
    end else begin
      dd_mag   = {16'd0, cond_neg16(l_x[15:0], dd_neg)};
      dv_mag   = {8'd0, cond_neg8(l_y[7:0], dv_neg)};
      rem_init = {8'd0, dd_mag[15:8]};
      quo_init = {dd_mag[7:0], 8'd0};
    end
    // Quotient cannot fit in n bits (also catches a zero divisor).
    over = (rem_init >= dv_mag);
  end

  always_comb begin
    qm        = word_q ? quo_q : {8'd0, quo_q[7:0]};
    rm        = word_q ? rem_q : {8'd0, rem_q[7:0]};
    qs        = cond_neg16(qm, qneg_q);
    rs        = cond_neg16(rm, rneg_q);
    range_exc = sgn_q & (word_q ? qm[15] : qm[7]);
    fix_out   = pack_result(word_q, qs, rs);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    out_d   = out_q;
    exc_d   = exc_q;
    pend_d  = pend_q;
    px_d    = px_q;
    py_d    = py_q;
    psgn_d  = psgn_q;
    pword_d = pword_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          pend_d = 1'b0;
          if (over) begin
            exc_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            rem_d   = rem_init;
            quo_d   = quo_init;
            dvsr_d  = dv_mag;
            cnt_d   = l_word ? 5'(DIV_ITERS_W) : 5'(DIV_ITERS_B);
            word_d  = l_word;
            sgn_d   = l_sgn;
            qneg_d  = dd_neg ^ dv_neg;
            rneg_d  = dd_neg;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = ST_FIX;
      end
      ST_FIX: begin
        exc_d = range_exc;
        if (!range_exc) out_d = fix_out;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          pend_d  = 1'b1;
          px_d    = x;
          py_d    = y;
          psgn_d  = signed_op;
          pword_d = word_op;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= 1'b0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      out_q   <= '0;
      exc_q   <= 1'b0;
      pend_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      psgn_q  <= 1'b0;
      pword_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      out_q   <= out_d;
      exc_q   <= exc_d;
      pend_q  <= pend_d;
      px_q    <= px_d;
      py_q    <= py_d;
      psgn_q  <= psgn_d;
      pword_q <= pword_d;
    end
  end

  assign busy    = (state_q == ST_DIV) || (state_q == ST_FIX);
  assign done    = (state_q == ST_DONE);
  assign out     = out_q;
  assign div_exc = exc_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: stimulus pushes hand-computed results into
// a scoreboard queue; a negedge monitor checks every done pulse against it.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, signed_op, word_op;
  logic [31:0] x;
  logic [15:0] y;
  logic        busy, done, div_exc;
  logic [31:0] out;

  always #5 clk = ~clk;

  div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .signed_op (signed_op),
    .word_op   (word_op),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .div_exc   (div_exc)
  );

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] model_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cyc=%0d actual=1 required=0", cyc);
      end else begin
        e = sb.pop_front();
        $display("op %-14s cyc=%0d out=0x%08h div_exc=%0b", e.name, cyc, out, div_exc);
        chk({e.name, "_out"}, out, e.out);
        chk({e.name, "_exc"}, {31'd0, div_exc}, {31'd0, e.exc});
        chk({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1; drives start for the current cycle only.
  task automatic issue(input string name, input logic [31:0] xi, input logic [15:0] yi,
                       input logic s, input logic w, input logic [31:0] eo,
                       input logic ee, input int lat, input bit push);
    exp_t e;
    x = xi; y = yi; signed_op = s; word_op = w; start = 1'b1;
    if (push) begin
      e.name = name;
      e.exc  = ee;
      e.out  = ee ? model_out : eo;
      if (!ee) model_out = eo;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    x = $urandom; y = 16'($urandom); signed_op = 1'($urandom); word_op = 1'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; signed_op = 1'b0; word_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_out", out, 32'd0);
    chk("reset_exc", {31'd0, div_exc}, 32'd0);
    @(posedge clk); #1;

    issue("uw_basic", 32'h0001_0000, 16'h0003, 1'b0, 1'b1, 32'h0001_5555, 1'b0, 18, 1);
    wait_drain();
    issue("sb_neg", 32'h1234_FF9C, 16'hAB07, 1'b1, 1'b0, 32'h0000_FEF2, 1'b0, 10, 1);
    wait_drain();
    issue("sw_negdiv", 32'h0000_0064, 16'hFFF9, 1'b1, 1'b1, 32'h0002_FFF2, 1'b0, 18, 1);
    wait_drain();
    issue("uw_div0", 32'h0000_1234, 16'h0000, 1'b0, 1'b1, 32'h0, 1'b1, 1, 1);
    wait_drain();
    issue("uw_ovf", 32'h0002_0000, 16'h0002, 1'b0, 1'b1, 32'h0, 1'b1, 1, 1);
    wait_drain();
    issue("ub_div0_hi", 32'h0000_0010, 16'hFF00, 1'b0, 1'b0, 32'h0, 1'b1, 1, 1);
    wait_drain();
    issue("sb_m128", 32'h0000_FF80, 16'h0001, 1'b1, 1'b0, 32'h0, 1'b1, 10, 1);
    wait_drain();
    issue("sb_p127", 32'h0000_007F, 16'h0001, 1'b1, 1'b0, 32'h0000_007F, 1'b0, 10, 1);
    wait_drain();

    // Starts while busy must be ignored (these operands would trap if taken).
    s = cyc;
    issue("sw_busy", 32'hFFFF_FC18, 16'h0007, 1'b1, 1'b1, 32'hFFFA_FF72, 1'b0, 18, 1);
    wait_until(s + 3);
    x = 32'h0000_0001; y = 16'h0000; word_op = 1'b1; start = 1'b1;
    wait_until(s + 4);
    chk("busy_mid_op", {31'd0, busy}, 32'd1);
    wait_until(s + 6);
    start = 1'b0;
    wait_drain();

    // Reset mid-operation aborts with no done, then a fresh op completes.
    s = cyc;
    issue("sw_abort", 32'h0001_0000, 16'h0003, 1'b0, 1'b1, 32'h0, 1'b0, 18, 0);
    wait_until(s + 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_out = '0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", out, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    wait_until(s + 9);
    issue("uw_after_rst", 32'h0012_3456, 16'h1000, 1'b0, 1'b1, 32'h0456_0123, 1'b0, 18, 1);
    wait_drain();

    // Back-to-back: each start lands in the previous op's done cycle.
    s = cyc;
    issue("b2b_a", 32'h0001_0000, 16'h0003, 1'b0, 1'b1, 32'h0001_5555, 1'b0, 18, 1);
    wait_until(s + 18);
    issue("b2b_b", 32'h0000_FF9C, 16'h0007, 1'b1, 1'b0, 32'h0000_FEF2, 1'b0, 1 + 10, 1);
    wait_until(s + 18 + 11);
    issue("b2b_c_div0", 32'h0000_1234, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b1, 1 + 1, 1);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
